sobel_prod_norm: RTL
====================

# sobel_prod_norm

Downstream stage of the Sobel datapath's 13x11 unsigned pipelined multiplier. It owns the multiplier's clock enable and tracks which products are valid through the multiplier's two register stages. Each valid 24-bit product is rounded, right-shifted and saturated to an 8-bit pixel, then buffered in a small FIFO. Pixels leave on a valid/ready stream with an end-of-line flag.

## Interface
- DIN_WIDTH, 24: product width from the multiplier.
- SHIFT, 8: right-shift applied to the product (range 1..16).
- DOUT_WIDTH, 8: output pixel width.
- LINE_LEN, 640: pixels per line; sets `m_last` spacing (2..4095).
- FIFO_DEPTH, 4: output FIFO entries (power of 2, ≥2).

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- op_valid, in, 1: operands are presented to the multiplier this cycle.
- op_ready, out, 1: equals `mul_ce`. An operand is accepted when `op_valid && op_ready`.
- mul_ce, out, 1: clock enable to the multiplier.
- mul_reset, out, 1: active-high reset to the multiplier; equals `!reset` (combinational).
- mul_dout, in, DIN_WIDTH: multiplier product (`p` register output).
- m_valid, out, 1: output pixel available.
- m_ready, in, 1: downstream accepts the pixel.
- m_data, out, DOUT_WIDTH: normalized pixel.
- m_last, out, 1: `m_data` is the last pixel of a line.

## Operation
**Valid tracking**
- Two flags, `v1` and `v2`, mirror the multiplier's operand and product registers.
- On an edge with `mul_ce=1`: `v1 <= op_valid`, `v2 <= v1`.
- With `mul_ce=0` both flags hold, as does the multiplier.
- `v2=1` means `mul_dout` holds a valid, not-yet-consumed product.

**Enable / backpressure**
- `mul_ce = !(v2 && full)`, combinational.
- With no input, the pipeline keeps draining while `op_valid=0`; bubbles are legal.

**Normalization**
- Combinational on `mul_dout`:
  - `r = (mul_dout + 2^(SHIFT-1)) >> SHIFT`, computed at DIN_WIDTH+1 bits (no wrap).
  - Output = `r` if `r ≤ 2^DOUT_WIDTH − 1`, else `2^DOUT_WIDTH − 1`.

**FIFO**
- Register array with `rd_ptr`, `wr_ptr` and `count` (0..FIFO_DEPTH).
- Write = `v2 && mul_ce`: the product is captured on the same edge the multiplier advances past it. Each product is written exactly once.
- Read = `m_valid && m_ready`.
- Pointers wrap modulo FIFO_DEPTH.
- Simultaneous read and write: `count` unchanged.
- `full = (count == FIFO_DEPTH)`. When full, the write is blocked even if a read occurs in the same cycle. A write then proceeds on the next cycle, so there is one bubble.
- `m_valid = (count != 0)`; `m_data = mem[rd_ptr]`.

**Line counter**
- `col` counts 0..LINE_LEN−1 and advances on each read.
- Wraps to 0 after LINE_LEN−1.
- `m_last = m_valid && (col == LINE_LEN−1)`.

**Reset (asserted)**
- `v1`, `v2`, `count`, pointers, `col` and all FIFO entries are cleared to 0.
- `m_valid=0`, `m_data=0`, `m_last=0`.
- `mul_ce=op_ready=1` and `mul_reset=1`.
- Reset mid-stream discards all in-flight products and buffered pixels. The line position restarts at 0.

## Timing
- Acceptance at edge k sets `v1`. Edge k+1 computes the product and sets `v2`. Edge k+2 writes the FIFO.
- `m_valid` rises after edge k+2 when the FIFO was empty: 3-cycle latency.
- Throughput: 1 pixel/cycle while `m_ready=1`.
- `m_valid`, `m_data` and `m_last` are held stable until accepted.
- `mul_ce` depends only on registered state, with no path from `m_ready`.
- After `reset` is deasserted, the first acceptance is possible on the first edge.

## Test plan
- **Single product:** `mul_dout=384` with SHIFT=8 → `m_data=2`, `m_valid` high 3 cycles after acceptance.
- **Rounding and saturation:**
  - 127 → 0.
  - 128 → 1.
  - 0xFF80 → 255 (r=256, saturated).
  - 0xFFFFFF → 255.
- **Continuous stream:** 1300 operands with `m_ready=1` → 1300 pixels in order, `m_last` at pixel indices 639 and 1279 only, no bubbles.
- **Backpressure:** `m_ready=0` for 20 cycles under a continuous stream.
  - Exactly 4 pixels buffered, `mul_ce=0` while `v2` is set.
  - On release, no loss or duplication; the sequence matches the reference model.
- **Random `op_valid`/`m_ready` (50%/50%), 10k pixels:** scoreboard match, and `count` never exceeds FIFO_DEPTH.
- **Reset mid-stream:**
  - Assert `reset` with 3 pixels buffered and `v1=v2=1` → all outputs 0 immediately.
  - After release, the next pixel has `col=0` and no stale data appears.

Source files
------------

// File: rtl/sobel_prod_norm_if.sv
// Stream and multiplier-control signals between sobel_prod_norm and its
// neighbours: operand handshake, multiplier enable/reset/product, and the
// normalized pixel output stream.
interface sobel_prod_norm_if #(
    parameter int DIN_WIDTH  = 24,
    parameter int DOUT_WIDTH = 8
);
    logic                  op_valid;
    logic                  op_ready;
    logic                  mul_ce;
    logic                  mul_reset;
    logic [DIN_WIDTH-1:0]  mul_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DOUT_WIDTH-1:0] m_data;
    logic                  m_last;

    // View of the normalization stage itself.
    modport slave (
        input  op_valid, mul_dout, m_ready,
        output op_ready, mul_ce, mul_reset, m_valid, m_data, m_last
    );

    // View of the surrounding environment (operand source, multiplier, sink).
    modport master (
        output op_valid, mul_dout, m_ready,
        input  op_ready, mul_ce, mul_reset, m_valid, m_data, m_last
    );
endinterface

// File: rtl/sobel_prod_norm.sv
// Back end of the Sobel 13x11 multiplier: tracks product validity through the
// multiplier's two register stages, owns its clock enable, rounds/shifts/
// saturates each product to a pixel and buffers pixels in a small FIFO that
// drives a valid/ready stream with an end-of-line flag.
module sobel_prod_norm #(
    parameter int DIN_WIDTH  = 24,
    parameter int SHIFT      = 8,
    parameter int DOUT_WIDTH = 8,
    parameter int LINE_LEN   = 640,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    sobel_prod_norm_if.slave   io
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

    localparam logic [DIN_WIDTH:0] ROUND   = (DIN_WIDTH+1)'(1) << (SHIFT - 1);
    localparam logic [DIN_WIDTH:0] MAX_PIX = (DIN_WIDTH+1)'((1 << DOUT_WIDTH) - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [COL_W-1:0]   LAST_COL = COL_W'(LINE_LEN - 1);

    // Round-half-up, shift, and clamp to the pixel range. The sum is kept one
    // bit wider than the product so a near-full-scale product cannot wrap.
    function automatic logic [DOUT_WIDTH-1:0] normalize(input logic [DIN_WIDTH-1:0] p);
        logic [DIN_WIDTH:0] sum;
        logic [DIN_WIDTH:0] r;
        sum = {1'b0, p} + ROUND;
        r   = sum >> SHIFT;
        if (r > MAX_PIX) begin
            return {DOUT_WIDTH{1'b1}};
        end else begin
            return r[DOUT_WIDTH-1:0];
        end
    endfunction

    logic                  v1;
    logic                  v2;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [COL_W-1:0]      col;
    logic [DOUT_WIDTH-1:0] mem [FIFO_DEPTH];

    logic full;
    logic ce;
    logic wr_en;
    logic rd_en;
    logic valid;

    // The multiplier stalls only when a finished product has nowhere to go;
    // this depends on registered state only, never on m_ready.
    assign full  = (count == FULL_CNT);
    assign ce    = !(v2 && full);
    assign wr_en = v2 && ce;
    assign valid = (count != '0);
    assign rd_en = valid && io.m_ready;

    assign io.mul_ce    = ce;
    assign io.op_ready  = ce;
    assign io.mul_reset = !reset;
    assign io.m_valid   = valid;
    assign io.m_data    = mem[rd_ptr];
    assign io.m_last    = valid && (col == LAST_COL);

    // Validity flags shadow the multiplier's operand and product registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (ce) begin
            v1 <= io.op_valid;
            v2 <= v1;
        end else begin
            v1 <= v1;
            v2 <= v2;
        end
    end

    // FIFO storage: each valid product is written once, as the multiplier
    // advances past it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= normalize(io.mul_dout);
        end
    end

    // FIFO pointers and occupancy; power-of-two depth makes the pointers wrap
    // naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Column position within the current line, advanced per delivered pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
        end else if (rd_en) begin
            if (col == LAST_COL) begin
                col <= '0;
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end
endmodule
